vector_alu_sequencer: RTL and testbench

Time-multiplexes one scalar `alu` instance across the lanes of a vector operation, one lane per clock. The vector CPU's execute stage issues a vector opcode and two packed operand vectors. The block latches them, steps a lane counter, and writes each lane's result into a packed result register. It also captures per-lane CMP flags and returns a one-cycle completion pulse.

---
 rtl/alu_defs.sv | 25 ++
 rtl/alu.sv | 42 ++++
 rtl/vector_alu_sequencer.sv | 126 ++++++++++++
 tb/tb_vector_alu_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Package : alu_defs
// Desc    : Scalar ALU opcodes and the vector sequencer state encoding.
// Rev     : 1.0
// ============================================================================
package alu_defs;

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_mov = 3'd1;
  localparam logic [2:0] c_op_xor = 3'd2;
  localparam logic [2:0] c_op_or  = 3'd3;
  localparam logic [2:0] c_op_shr = 3'd4;
  localparam logic [2:0] c_op_shl = 3'd5;
  localparam logic [2:0] c_op_cmp = 3'd6;
  localparam logic [2:0] c_op_sub = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Desc   : Combinational scalar ALU; flags[0] = zero of a-b, flags[1] = signed a<b.
// Rev    : 1.0
// ============================================================================
module alu
  import alu_defs::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [N-1:0] result_o,
  output logic [1:0]   alu_flags_o
);

  logic [N-1:0] w_diff;

  assign w_diff = a_i - b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      c_op_add: result_o = a_i + b_i;
      c_op_mov: result_o = b_i;
      c_op_xor: result_o = a_i ^ b_i;
      c_op_or:  result_o = a_i | b_i;
      c_op_shr: result_o = a_i >> b_i[2:0];
      c_op_shl: result_o = a_i << b_i[2:0];
      c_op_cmp: result_o = w_diff;
      c_op_sub: result_o = w_diff;
      default:  result_o = '0;
    endcase
  end

  assign alu_flags_o[0] = (w_diff == '0);
  assign alu_flags_o[1] = ($signed(a_i) < $signed(b_i));

endmodule
`default_nettype wire

// File: rtl/vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : vector_alu_sequencer
// Desc   : Steps one scalar ALU across the lanes of a latched vector op.
// Rev    : 1.0
// ============================================================================
module vector_alu_sequencer
  import alu_defs::*;
#(
  parameter int N     = 8,
  parameter int LANES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [2:0]         opcode_i,
  input  logic [LANES*N-1:0] va_i,
  input  logic [LANES*N-1:0] vb_i,
  input  logic [LANES-1:0]   mask_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [LANES*N-1:0] vr_o,
  output logic [LANES-1:0]   zero_o,
  output logic [LANES-1:0]   sign_o
);

  localparam int              CW          = $clog2(LANES);
  localparam logic [CW-1:0]   c_last_lane = CW'(LANES - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [LANES*N-1:0] r_va;
  logic [LANES*N-1:0] r_vb;
  logic [LANES*N-1:0] r_vr;
  logic [LANES-1:0]   r_mask;
  logic [LANES-1:0]   r_zero;
  logic [LANES-1:0]   r_sign;

  logic [N-1:0]       w_a;
  logic [N-1:0]       w_b;
  logic [N-1:0]       w_result;
  logic [1:0]         w_flags;
  logic               w_accept;
  logic               w_last;
  logic               w_is_cmp;
  logic               w_lane_en;

  assign w_a       = r_va[r_cnt*N +: N];
  assign w_b       = r_vb[r_cnt*N +: N];
  assign w_accept  = (r_state == IDLE) && start_i;
  assign w_last    = (r_cnt == c_last_lane);
  assign w_is_cmp  = (r_op == c_op_cmp);
  assign w_lane_en = r_mask[r_cnt];

  alu #(.N(N)) alu_inst (
    .a_i         (w_a),
    .b_i         (w_b),
    .op_i        (r_op),
    .result_o    (w_result),
    .alu_flags_o (w_flags)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_state_nxt = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flags are forced to 0 for non-CMP or masked lanes so ALU flag state never leaks out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_op   <= c_op_add;
      r_va   <= '0;
      r_vb   <= '0;
      r_mask <= '0;
      r_vr   <= '0;
      r_zero <= '0;
      r_sign <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_op   <= opcode_i;
      r_va   <= va_i;
      r_vb   <= vb_i;
      r_mask <= mask_i;
    end else if (r_state == RUN) begin
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      if (w_lane_en) r_vr[r_cnt*N +: N] <= w_result;
      r_zero[r_cnt] <= (w_lane_en && w_is_cmp) ? w_flags[0] : 1'b0;
      r_sign[r_cnt] <= (w_lane_en && w_is_cmp) ? w_flags[1] : 1'b0;
    end
  end

  assign vr_o   = r_vr;
  assign zero_o = r_zero;
  assign sign_o = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_vector_alu_sequencer
// Desc   : Directed self-checking bench for vector_alu_sequencer (N=8, LANES=4).
// Rev    : 1.0
// ============================================================================
module tb_vector_alu_sequencer;
  import alu_defs::*;

  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int W     = N * LANES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] va;
  logic [W-1:0] vb;
  logic [3:0]   mask;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] vr;
  logic [3:0]   zero;
  logic [3:0]   sign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vector_alu_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .opcode_i (opcode),
    .va_i     (va),
    .vb_i     (vb),
    .mask_i   (mask),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done),
    .vr_o     (vr),
    .zero_o   (zero),
    .sign_o   (sign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; returns during the DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [3:0] m);
    int cyc;
    opcode = op; va = a; vb = b; mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opcode = c_op_or; va = '1; vb = '1; mask = 4'h0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done latency"}, cyc, 4);
  endtask

  task automatic back_to_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, " done pulse ends"}, done, 0);
    chk({tag, " ready after done"}, ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = c_op_add; va = '0; vb = '0; mask = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset vr", vr, 32'h0);
    chk("reset zero/sign", {zero, sign}, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain ADD across all lanes
    do_op("t1 add", c_op_add, 32'h04030201, 32'h10101010, 4'hF);
    chk("t1 vr", vr, 32'h14131211);
    chk("t1 zero", zero, 4'b0000);
    chk("t1 sign", sign, 4'b0000);
    back_to_idle("t1");

    // CMP: equal lanes set zero, signed-less lanes set sign
    do_op("t2 cmp", c_op_cmp, 32'h05800700, 32'h05010900, 4'hF);
    chk("t2 zero", zero, 4'b1001);
    chk("t2 sign", sign, 4'b0110);
    chk("t2 vr", vr, 32'h007FFE00);
    back_to_idle("t2");

    // Masked SHL over a preloaded result: lanes 1 and 3 keep their values
    do_op("t3 preload", c_op_add, 32'h04030201, 32'h10101010, 4'hF);
    chk("t3 preload vr", vr, 32'h14131211);
    back_to_idle("t3 preload");
    do_op("t3 shl", c_op_shl, 32'h14131211, 32'h01010101, 4'b0101);
    chk("t3 vr", vr, 32'h14261222);
    chk("t3 zero/sign", {zero, sign}, 8'h00);
    back_to_idle("t3");

    // start held high: second accept only once the block is back in IDLE
    opcode = c_op_add; va = 32'h04030201; vb = 32'h10101010; mask = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    chk("t4 first accept busy", busy, 1);
    opcode = c_op_xor; va = 32'h0F0F0F0F; vb = 32'hFF00FF00;
    repeat (4) @(posedge clk);
    #1;
    chk("t4 first done", done, 1);
    chk("t4 first vr uses accepted opcode", vr, 32'h14131211);
    @(posedge clk); #1;
    chk("t4 start ignored in done", ready, 1);
    @(posedge clk); #1;
    chk("t4 second accept busy", busy, 1);
    opcode = c_op_sub; va = 32'h0; vb = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    #1;
    chk("t4 second done", done, 1);
    chk("t4 second vr", vr, 32'hF00FF00F);
    start = 1'b0;
    back_to_idle("t4");

    // Asynchronous reset after lane 1 has been written
    opcode = c_op_add; va = 32'h04030201; vb = 32'h10101010; mask = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5 lanes 0-1 written", vr, 32'hF00F1211);
    #2 rst = 1'b1;
    #1;
    chk("t5 async vr", vr, 32'h0);
    chk("t5 async ready", ready, 1);
    chk("t5 async busy/done", {busy, done}, 2'b00);
    chk("t5 async zero/sign", {zero, sign}, 8'h00);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // SUB borrow stays inside lane 0; sign not written for non-CMP
    do_op("t6 sub", c_op_sub, 32'h55443300, 32'h11111101, 4'hF);
    chk("t6 vr", vr, 32'h443322FF);
    chk("t6 sign", sign, 4'b0000);
    chk("t6 zero", zero, 4'b0000);
    back_to_idle("t6");

    // Logical right shift with per-lane amounts
    do_op("t7 shr", c_op_shr, 32'h80402010, 32'h07030201, 4'hF);
    chk("t7 vr", vr, 32'h01080808);
    back_to_idle("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
